jt5205_seq: RTL and testbench

- ADPCM playback sequencer for the MSM5205-compatible core.
- Fetches packed ADPCM bytes from sample ROM between a start and an end address.
- Splits each byte into nibbles and presents one nibble on din per core strobe (irq).
- Holds the ADPCM core in reset while idle, mirroring the sample-latch/counter logic of typical arcade boards.

---
 rtl/jt5205_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_jt5205_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt5205_seq.sv
// rtl/jt5205_seq.sv - ADPCM playback sequencer feeding nibbles to an MSM5205-style core
//
// Fetches packed ADPCM bytes from sample ROM between a start and an inclusive
// end address and hands one nibble to the core on every irq strobe. The core
// is held in reset whenever no sample is playing.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   irq                   one-cycle sample strobe from the ADPCM core
//   start, stop           one-cycle control pulses (stop wins if both arrive)
//   start_addr, end_addr  sample bounds, end inclusive, latched on start
//   rom_addr, rom_cs      ROM request, held until rom_ok
//   rom_ok, rom_data      ROM acknowledge with data valid in the same cycle
//   din                   nibble presented to the ADPCM core
//   adpcm_rst             core reset, high while not playing
//   busy                  high while fetching or playing
//   done                  one-cycle pulse at the natural end of a sample
//   underrun              sticky: a nibble was due but no byte was buffered

module jt5205_seq #(
  parameter int AW       = 18,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          irq,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [7:0]    rom_data,
  output logic [3:0]    din,
  output logic          adpcm_rst,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] end_q, end_d;
  logic          cs_q, cs_d;
  logic          rem_q, rem_d;        // at least one byte still to be fetched
  logic [7:0]    cur_q, cur_d;        // byte being played
  logic [7:0]    nxt_q, nxt_d;        // prefetched byte
  logic          nxt_vld_q, nxt_vld_d;
  logic          nsel_q, nsel_d;      // 0 = first nibble of cur
  logic          need_q, need_d;      // cur exhausted, waiting on ROM
  logic [3:0]    din_q, din_d;
  logic          arst_q, arst_d;
  logic          done_q, done_d;
  logic          unr_q, unr_d;

  logic       byte_ok;
  logic       last_byte;
  logic       hi_sel;
  logic [3:0] cur_nib;
  logic       refill;

  assign byte_ok   = cs_q & rom_ok;
  // Address compare against the latched end is only used while the request
  // is outstanding; "bytes remain" is tracked by rem_q so an end address at
  // the top of the address space still terminates correctly after a wrap.
  assign last_byte = (addr_q == end_q);
  assign hi_sel    = nsel_q ^ HI_FIRST;
  assign cur_nib   = hi_sel ? cur_q[7:4] : cur_q[3:0];
  // Second nibble leaves on this irq and no prefetched byte is waiting:
  // a byte arriving in the same cycle goes straight into cur.
  assign refill    = irq & ~need_q & nsel_q & ~nxt_vld_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    end_d     = end_q;
    cs_d      = cs_q;
    rem_d     = rem_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    nxt_vld_d = nxt_vld_q;
    nsel_d    = nsel_q;
    need_d    = need_q;
    din_d     = din_q;
    arst_d    = arst_q;
    done_d    = 1'b0;
    unr_d     = unr_q;

    case (state_q)
      IDLE: begin
        cs_d   = 1'b0;
        arst_d = 1'b1;
      end

      FETCH: begin
        if (byte_ok) begin
          cur_d   = rom_data;
          nsel_d  = 1'b0;
          need_d  = 1'b0;
          cs_d    = 1'b0;
          arst_d  = 1'b0;
          state_d = PLAY;
          if (!last_byte) begin
            addr_d = addr_q + 1'b1;
          end else begin
            rem_d = 1'b0;
          end
        end
      end

      PLAY: begin
        if (irq) begin
          if (need_q) begin
            // No data for this strobe: din holds and the nibble pointer stays.
            unr_d = 1'b1;
          end else begin
            din_d  = cur_nib;
            nsel_d = ~nsel_q;
            if (nsel_q) begin
              if (nxt_vld_q) begin
                cur_d     = nxt_q;
                nxt_vld_d = 1'b0;
              end else if (!byte_ok) begin
                if (rem_q) begin
                  need_d = 1'b1;
                end else begin
                  state_d = IDLE;
                  arst_d  = 1'b1;
                  done_d  = 1'b1;
                end
              end
            end
          end
        end

        if (byte_ok) begin
          cs_d   = 1'b0;
          addr_d = addr_q + 1'b1;
          rem_d  = ~last_byte;
          if (need_q || refill) begin
            // nsel is already 0 here: it flipped when the second nibble left.
            cur_d  = rom_data;
            need_d = 1'b0;
          end else begin
            nxt_d     = rom_data;
            nxt_vld_d = 1'b1;
          end
        end else if (!cs_q && !nxt_vld_d && rem_q) begin
          cs_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        arst_d  = 1'b1;
      end
    endcase

    // Control pulses override the sequencing above; stop has priority.
    if (stop) begin
      state_d   = IDLE;
      cs_d      = 1'b0;
      arst_d    = 1'b1;
      nxt_vld_d = 1'b0;
      need_d    = 1'b0;
      done_d    = 1'b0;
    end else if (start) begin
      nxt_vld_d = 1'b0;
      need_d    = 1'b0;
      nsel_d    = 1'b0;
      din_d     = 4'd0;
      arst_d    = 1'b1;
      if (start_addr > end_addr) begin
        // Empty sample: report completion without touching the ROM.
        state_d = IDLE;
        cs_d    = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = FETCH;
        end_d   = end_addr;
        addr_d  = start_addr;
        cs_d    = 1'b1;
        rem_d   = 1'b1;
        unr_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      end_q     <= '0;
      cs_q      <= 1'b0;
      rem_q     <= 1'b0;
      cur_q     <= 8'd0;
      nxt_q     <= 8'd0;
      nxt_vld_q <= 1'b0;
      nsel_q    <= 1'b0;
      need_q    <= 1'b0;
      din_q     <= 4'd0;
      arst_q    <= 1'b1;
      done_q    <= 1'b0;
      unr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      end_q     <= end_d;
      cs_q      <= cs_d;
      rem_q     <= rem_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      nxt_vld_q <= nxt_vld_d;
      nsel_q    <= nsel_d;
      need_q    <= need_d;
      din_q     <= din_d;
      arst_q    <= arst_d;
      done_q    <= done_d;
      unr_q     <= unr_d;
    end
  end

  assign rom_addr  = addr_q;
  assign rom_cs    = cs_q;
  assign din       = din_q;
  assign adpcm_rst = arst_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign underrun  = unr_q;

endmodule

// File: tb/tb_jt5205_seq.sv
// tb/tb_jt5205_seq.sv - directed scoreboard bench for jt5205_seq (both nibble orders)

module tb_jt5205_seq;
  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, irq, start, stop;
  logic [AW-1:0] start_addr, end_addr;
  logic          rom_ok_a = 1'b0;
  logic [7:0]    rom_data_a = 8'd0;
  logic          rom_ok_m;
  wire           rom_ok   = rom_ok_a | rom_ok_m;
  wire  [7:0]    rom_data = rom_ok_m ? 8'hEE : rom_data_a;

  logic [AW-1:0] rom_addr, rom_addr0;
  logic          rom_cs, rom_cs0;
  logic [3:0]    din, din0;
  logic          adpcm_rst, adpcm_rst0, busy, busy0, done, done0, underrun, underrun0;

  jt5205_seq #(.AW(AW), .HI_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .din(din), .adpcm_rst(adpcm_rst), .busy(busy), .done(done), .underrun(underrun)
  );

  jt5205_seq #(.AW(AW), .HI_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .irq(irq), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr),
    .rom_addr(rom_addr0), .rom_cs(rom_cs0), .rom_ok(rom_ok), .rom_data(rom_data),
    .din(din0), .adpcm_rst(adpcm_rst0), .busy(busy0), .done(done0), .underrun(underrun0)
  );

  // ROM model: answers a held rom_cs after a per-address number of cycles.
  logic [7:0]    rom_mem [0:255];
  int            rom_dly, slow_dly;
  logic [AW-1:0] slow_addr;
  int            wait_cnt = 0;
  int            nreq = 0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    rom_ok_a = 1'b0;
    if (rom_cs) begin
      wait_cnt++;
      if (wait_cnt >= ((rom_addr == slow_addr) ? slow_dly : rom_dly)) begin
        rom_ok_a   = 1'b1;
        rom_data_a = rom_mem[rom_addr[7:0]];
        wait_cnt   = 0;
        nreq++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (done) done_cnt++;
  end

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q1[$];
  logic [3:0] exp_q0[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic irq_step(input string tag, input int gap, input logic [3:0] e1, input logic [3:0] e0);
    repeat (gap - 1) @(negedge clk);
    exp_q1.push_back(e1);
    exp_q0.push_back(e0);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    chk({tag, "/din_hi_first"}, {28'd0, din}, {28'd0, exp_q1.pop_front()});
    chk({tag, "/din_lo_first"}, {28'd0, din0}, {28'd0, exp_q0.pop_front()});
  endtask

  task automatic do_start(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_play(input string tag);
    int n = 0;
    while (adpcm_rst !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/enter_play"}, {31'd0, (n < 200)}, 32'd1);
  endtask

  task automatic wait_nreq(input string tag, input int target);
    int n = 0;
    while (nreq < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/rom_reply"}, {31'd0, (n < 200)}, 32'd1);
  endtask

  int n0, d0;

  initial begin
    rst_n = 1'b0; irq = 1'b0; start = 1'b0; stop = 1'b0; rom_ok_m = 1'b0;
    start_addr = '0; end_addr = '0;
    rom_dly = 2; slow_dly = 0; slow_addr = '1;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'hFF;
    rom_mem[8'h10] = 8'hA5; rom_mem[8'h11] = 8'h3C;
    rom_mem[8'h40] = 8'h12; rom_mem[8'h41] = 8'h34; rom_mem[8'h42] = 8'h56; rom_mem[8'h43] = 8'h78;
    rom_mem[8'h50] = 8'h77; rom_mem[8'h51] = 8'h88; rom_mem[8'h52] = 8'h77; rom_mem[8'h53] = 8'h88;
    rom_mem[8'h20] = 8'h96; rom_mem[8'h21] = 8'h1E;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst/rom_addr", {14'd0, rom_addr}, 32'd0);
    chk("rst/rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("rst/din", {28'd0, din}, 32'd0);
    chk("rst/adpcm_rst", {31'd0, adpcm_rst}, 32'd1);
    chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/done", {31'd0, done}, 32'd0);
    chk("rst/underrun", {31'd0, underrun}, 32'd0);
    chk("rst/lo_first_state", {26'd0, rom_cs0, din0, adpcm_rst0, busy0},
        {26'd0, 1'b0, 4'd0, 1'b1, 1'b0});
    chk("rst/lo_first_addr", {14'd0, rom_addr0}, 32'd0);
    chk("rst/lo_first_flags", {30'd0, done0, underrun0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic playback, both nibble orders
    n0 = nreq; d0 = done_cnt;
    do_start(18'h10, 18'h11);
    chk("basic/busy", {31'd0, busy}, 32'd1);
    chk("basic/rom_cs", {31'd0, rom_cs}, 32'd1);
    chk("basic/rom_addr", {14'd0, rom_addr}, 32'h10);
    chk("basic/adpcm_rst_fetch", {31'd0, adpcm_rst}, 32'd1);
    wait_play("basic");
    irq_step("basic1", 16, 4'hA, 4'h5);
    irq_step("basic2", 16, 4'h5, 4'hA);
    irq_step("basic3", 16, 4'h3, 4'hC);
    chk("basic/no_early_done", done_cnt - d0, 32'd0);
    irq_step("basic4", 16, 4'hC, 4'h3);
    chk("basic/done", {31'd0, done}, 32'd1);
    chk("basic/done_lo_first", {31'd0, done0}, 32'd1);
    chk("basic/adpcm_rst_end", {31'd0, adpcm_rst}, 32'd1);
    chk("basic/busy_end", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("basic/done_one_cycle", {31'd0, done}, 32'd0);
    chk("basic/rom_requests", nreq - n0, 32'd2);
    chk("basic/done_count", done_cnt - d0, 32'd1);
    chk("basic/underrun", {31'd0, underrun}, 32'd0);

    // Underrun: second byte is late
    slow_addr = 18'h11; slow_dly = 40;
    n0 = nreq; d0 = done_cnt;
    do_start(18'h10, 18'h11);
    wait_play("under");
    irq_step("under1", 8, 4'hA, 4'h5);
    irq_step("under2", 8, 4'h5, 4'hA);
    irq_step("under3_stall", 8, 4'h5, 4'hA);
    chk("under/flag", {31'd0, underrun}, 32'd1);
    chk("under/flag_lo_first", {31'd0, underrun0}, 32'd1);
    wait_nreq("under", n0 + 2);
    irq_step("under4", 8, 4'h3, 4'hC);
    irq_step("under5", 8, 4'hC, 4'h3);
    chk("under/done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("under/sticky", {31'd0, underrun}, 32'd1);
    chk("under/done_count", done_cnt - d0, 32'd1);
    slow_addr = '1;

    // Stop mid-play with a request outstanding, then a stray rom_ok
    slow_addr = 18'h42; slow_dly = 30;
    d0 = done_cnt;
    do_start(18'h40, 18'h43);
    chk("stop/underrun_cleared", {31'd0, underrun}, 32'd0);
    wait_play("stop");
    irq_step("stop1", 16, 4'h1, 4'h2);
    irq_step("stop2", 16, 4'h2, 4'h1);
    repeat (2) @(negedge clk);
    chk("stop/prefetch_pending", {31'd0, rom_cs}, 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop/busy", {31'd0, busy}, 32'd0);
    chk("stop/rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("stop/adpcm_rst", {31'd0, adpcm_rst}, 32'd1);
    chk("stop/no_done", {31'd0, done}, 32'd0);
    rom_ok_m = 1'b1;
    @(negedge clk);
    rom_ok_m = 1'b0;
    @(negedge clk);
    chk("stop/late_ok_busy", {31'd0, busy}, 32'd0);
    chk("stop/late_ok_cs", {31'd0, rom_cs}, 32'd0);
    chk("stop/late_ok_rst", {31'd0, adpcm_rst}, 32'd1);
    chk("stop/done_count", done_cnt - d0, 32'd0);
    slow_addr = '1;

    // Restart during play
    d0 = done_cnt;
    do_start(18'h50, 18'h53);
    wait_play("restart_old");
    irq_step("restart_old1", 16, 4'h7, 4'h7);
    repeat (4) @(negedge clk);
    do_start(18'h20, 18'h21);
    chk("restart/rom_addr", {14'd0, rom_addr}, 32'h20);
    chk("restart/rom_cs", {31'd0, rom_cs}, 32'd1);
    chk("restart/busy", {31'd0, busy}, 32'd1);
    chk("restart/adpcm_rst", {31'd0, adpcm_rst}, 32'd1);
    chk("restart/no_old_nibble", {31'd0, (din == 4'h7 || din == 4'h8)}, 32'd0);
    wait_play("restart");
    irq_step("restart1", 16, 4'h9, 4'h6);
    irq_step("restart2", 16, 4'h6, 4'h9);
    irq_step("restart3", 16, 4'h1, 4'hE);
    irq_step("restart4", 16, 4'hE, 4'h1);
    chk("restart/done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("restart/done_count", done_cnt - d0, 32'd1);

    // Empty sample: start beyond end
    n0 = nreq; d0 = done_cnt;
    do_start(18'h30, 18'h2F);
    chk("empty/done", {31'd0, done}, 32'd1);
    chk("empty/busy", {31'd0, busy}, 32'd0);
    chk("empty/rom_cs", {31'd0, rom_cs}, 32'd0);
    repeat (5) @(negedge clk);
    chk("empty/no_rom", nreq - n0, 32'd0);
    chk("empty/done_count", done_cnt - d0, 32'd1);

    // Asynchronous reset while a fetch is pending
    slow_addr = 18'h60; slow_dly = 50;
    do_start(18'h60, 18'h61);
    chk("areset/pre_cs", {31'd0, rom_cs}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset/rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("areset/adpcm_rst", {31'd0, adpcm_rst}, 32'd1);
    chk("areset/busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("areset/idle", {31'd0, busy}, 32'd0);
    chk("areset/din", {28'd0, din}, 32'd0);
    chk("areset/rom_addr", {14'd0, rom_addr}, 32'd0);
    slow_addr = '1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
